// File: rtl/memory_stage_pipelined_if.sv
// Data-memory request/response bus between the memory stage and the memory.
// The stage is the master and the memory is the slave.
interface memory_stage_pipelined_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid,
    input  mem_req_ready,
    output mem_req_addr,
    output mem_req_we,
    output mem_req_wstrb,
    output mem_req_wdata,
    input  mem_rsp_valid,
    input  mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid,
    output mem_req_ready,
    input  mem_req_addr,
    input  mem_req_we,
    input  mem_req_wstrb,
    input  mem_req_wdata,
    output mem_rsp_valid,
    output mem_rsp_rdata
  );
endinterface

// File: rtl/memory_stage_pipelined.sv
// RV32 memory stage: loads/stores over a valid/ready data bus, holding
// the pipeline via done_mem until the access completes or is flushed.
module memory_stage_pipelined #(
  parameter logic [1:0]  LOAD_WB_SRC   = 2'b01,
  parameter logic [31:0] RESET_WB_DATA = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_mem,
  input  logic        flush_mem,
  input  logic        done_ex,
  input  logic [13:0] control_word_ex,
  input  logic [31:0] calculated_adr,
  input  logic [31:0] ALU_result,
  input  logic [31:0] regfileb_ex,
  memory_stage_pipelined_if.master mem,
  output logic        done_mem,
  output logic [31:0] wb_data,
  output logic        rf_wb_mem,
  output logic [4:0]  rd_mem,
  output logic        misaligned,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    DRAIN
  } state_t;

  state_t state;

  logic        rf_wb;
  logic        mem_we;
  logic [1:0]  wb_src;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic        is_st;
  logic        is_ld;
  logic        is_mem;
  logic        start;
  logic        f_byte;
  logic        f_half;
  logic        f_word;
  logic        mis;
  logic        unused_ctl;

  assign rf_wb  = control_word_ex[12];
  assign mem_we = control_word_ex[11];
  assign wb_src = control_word_ex[10:9];
  assign rd     = control_word_ex[7:3];
  assign f3     = control_word_ex[2:0];
  assign off    = calculated_adr[1:0];

  assign unused_ctl = control_word_ex[13] ^ control_word_ex[8];

  // A store wins when both the store and load encodings are present
  assign is_st  = mem_we;
  assign is_ld  = (wb_src == LOAD_WB_SRC) & ~mem_we;
  assign is_mem = is_st | is_ld;
  assign start  = valid_mem & done_ex & ~flush_mem;

  assign f_byte = (f3[1:0] == 2'b00);
  assign f_half = (f3[1:0] == 2'b01);
  assign f_word = ~f_byte & ~f_half;
  assign mis    = (f_half & off[0]) | (f_word & (|off));

  logic [3:0]  st_strb;
  logic [31:0] st_data;

  always_comb begin
    st_strb = 4'b1111;
    st_data = regfileb_ex;
    unique case (1'b1)
      f_byte: begin
        st_strb = 4'b0001 << off;
        st_data = {4{regfileb_ex[7:0]}};
      end
      f_half: begin
        st_strb = 4'b0011 << off;
        st_data = {2{regfileb_ex[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = regfileb_ex;
      end
    endcase
  end

  logic [29:0] adr_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        rf_wb_q;
  logic        st_q;
  logic        mis_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [31:0] ldata_q;

  logic        q_byte;
  logic        q_half;
  logic [31:0] shifted;
  logic [31:0] ld_val;

  assign q_byte  = (f3_q[1:0] == 2'b00);
  assign q_half  = (f3_q[1:0] == 2'b01);
  assign shifted = mem.mem_rsp_rdata >> {off_q, 3'b000};

  // funct3[2] selects the unsigned variants
  always_comb begin
    ld_val = shifted;
    unique case (1'b1)
      q_byte:
        ld_val = {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
      q_half:
        ld_val = {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]};
      default:
        ld_val = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      adr_q   <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      rf_wb_q <= 1'b0;
      st_q    <= 1'b0;
      mis_q   <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start & is_mem) begin
            adr_q   <= calculated_adr[31:2];
            off_q   <= off;
            f3_q    <= f3;
            rd_q    <= rd;
            rf_wb_q <= rf_wb;
            st_q    <= is_st;
            mis_q   <= mis;
            wstrb_q <= st_strb;
            wdata_q <= st_data;
            ldata_q <= '0;
            state   <= mis ? DONE : REQ;
          end
        end
        REQ: begin
          // An accepted write stands even when flushed
          if (mem.mem_req_ready) begin
            if (flush_mem)
              state <= st_q ? IDLE : DRAIN;
            else
              state <= st_q ? DONE : WAIT;
          end else if (flush_mem) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (flush_mem) begin
            state <= mem.mem_rsp_valid ? IDLE : DRAIN;
          end else if (mem.mem_rsp_valid) begin
            ldata_q <= ld_val;
            state   <= DONE;
          end
        end
        DRAIN: begin
          if (mem.mem_rsp_valid)
            state <= IDLE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  logic req_on;

  assign req_on = (state == REQ);
  assign busy   = (state != IDLE);

  assign mem.mem_req_valid = req_on;
  assign mem.mem_req_addr  = req_on ? {adr_q, 2'b00} : '0;
  assign mem.mem_req_we    = req_on & st_q;
  assign mem.mem_req_wstrb = (req_on & st_q) ? wstrb_q : '0;
  assign mem.mem_req_wdata = (req_on & st_q) ? wdata_q : '0;

  always_comb begin
    done_mem   = 1'b0;
    wb_data    = RESET_WB_DATA;
    rf_wb_mem  = 1'b0;
    rd_mem     = '0;
    misaligned = 1'b0;
    unique case (state)
      IDLE: begin
        if (start & ~is_mem) begin
          done_mem  = 1'b1;
          wb_data   = ALU_result;
          rf_wb_mem = rf_wb;
          rd_mem    = rd;
        end
      end
      DONE: begin
        if (!flush_mem) begin
          done_mem   = 1'b1;
          wb_data    = st_q ? '0 : ldata_q;
          rf_wb_mem  = rf_wb_q & ~st_q & ~mis_q;
          rd_mem     = rd_q;
          misaligned = mis_q;
        end
      end
      default: begin
        done_mem = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_stage_pipelined.sv
// Randomized bench for memory_stage_pipelined: a behavioural model of each
// instruction's outcome, a bus responder and one per-cycle compare process.
module tb_memory_stage_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_mem;
  logic        flush_mem;
  logic        done_ex;
  logic [13:0] control_word_ex;
  logic [31:0] calculated_adr;
  logic [31:0] ALU_result;
  logic [31:0] regfileb_ex;
  logic        done_mem;
  logic [31:0] wb_data;
  logic        rf_wb_mem;
  logic [4:0]  rd_mem;
  logic        misaligned;
  logic        busy;

  memory_stage_pipelined_if bus();

  memory_stage_pipelined dut (
    .clk             (clk),
    .rst             (rst),
    .valid_mem       (valid_mem),
    .flush_mem       (flush_mem),
    .done_ex         (done_ex),
    .control_word_ex (control_word_ex),
    .calculated_adr  (calculated_adr),
    .ALU_result      (ALU_result),
    .regfileb_ex     (regfileb_ex),
    .mem             (bus),
    .done_mem        (done_mem),
    .wb_data         (wb_data),
    .rf_wb_mem       (rf_wb_mem),
    .rd_mem          (rd_mem),
    .misaligned      (misaligned),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_n = 0;
  int done_at = 0;
  int acc_n = 0;

  logic [31:0] exp_wb;
  logic        exp_rfwb;
  logic [4:0]  exp_rd;
  logic        exp_mis;
  logic        exp_req_ok;
  logic [31:0] exp_addr;
  logic        exp_we;
  logic [3:0]  exp_wstrb;
  logic [31:0] exp_wdata;

  logic [31:0] last_wb;
  logic        last_rfwb;
  logic [4:0]  last_rd;
  logic        last_mis;
  logic [31:0] last_addr;
  logic        last_we;
  logic [3:0]  last_wstrb;
  logic [31:0] last_wdata;

  int          rdy_delay = 0;
  int          rsp_delay = 0;
  logic [31:0] rsp_data = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the expectations of the current instruction
  always @(negedge clk) begin
    if (done_mem) begin
      done_n++;
      done_at    = cyc;
      last_wb    = wb_data;
      last_rfwb  = rf_wb_mem;
      last_rd    = rd_mem;
      last_mis   = misaligned;
      chk("wb_data", wb_data, exp_wb);
      chk("rf_wb_mem", 32'(rf_wb_mem), 32'(exp_rfwb));
      chk("rd_mem", 32'(rd_mem), 32'(exp_rd));
      chk("misaligned", 32'(misaligned), 32'(exp_mis));
    end else begin
      chk("idle_wb_data", wb_data, 32'h0);
      chk("idle_rf_wb", 32'(rf_wb_mem), 32'h0);
      chk("idle_misaligned", 32'(misaligned), 32'h0);
    end
    if (bus.mem_req_valid) begin
      chk("req_allowed", 32'(exp_req_ok), 32'h1);
      chk("req_addr", bus.mem_req_addr, exp_addr);
      chk("req_we", 32'(bus.mem_req_we), 32'(exp_we));
      chk("req_wstrb", 32'(bus.mem_req_wstrb), 32'(exp_wstrb));
      chk("req_wdata", bus.mem_req_wdata, exp_wdata);
      if (bus.mem_req_ready) begin
        acc_n++;
        last_addr  = bus.mem_req_addr;
        last_we    = bus.mem_req_we;
        last_wstrb = bus.mem_req_wstrb;
        last_wdata = bus.mem_req_wdata;
      end
    end else begin
      chk("quiet_addr", bus.mem_req_addr, 32'h0);
      chk("quiet_we", 32'(bus.mem_req_we), 32'h0);
      chk("quiet_wstrb", 32'(bus.mem_req_wstrb), 32'h0);
      chk("quiet_wdata", bus.mem_req_wdata, 32'h0);
    end
    cyc++;
  end

  // Memory responder: ready after rdy_delay REQ cycles, one response per read
  initial begin
    logic acc;
    logic acc_we;
    logic fired;
    logic pend;
    int   rc;
    int   w;
    pend = 1'b0;
    rc   = 0;
    w    = 0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = 32'h0;
    forever begin
      @(negedge clk);
      acc    = bus.mem_req_valid & bus.mem_req_ready;
      acc_we = bus.mem_req_we;
      fired  = bus.mem_rsp_valid;
      @(posedge clk);
      #1;
      if (fired) pend = 1'b0;
      if (acc && !acc_we) begin
        pend = 1'b1;
        w    = 0;
      end
      if (pend) begin
        bus.mem_rsp_valid = (w >= rsp_delay);
        bus.mem_rsp_rdata = bus.mem_rsp_valid ? rsp_data : $urandom;
        w++;
      end else begin
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = $urandom;
      end
      if (bus.mem_req_valid) begin
        bus.mem_req_ready = (rc >= rdy_delay);
        rc++;
      end else begin
        bus.mem_req_ready = 1'b0;
        rc = 0;
      end
    end
  end

  function automatic logic [31:0] load_val(input logic [31:0] rdata,
                                           input int off, input int sz,
                                           input bit sgn);
    logic [31:0] v;
    logic [31:0] mask;
    v = rdata >> (8 * off);
    if (sz == 4) return v;
    mask = (32'h1 << (8 * sz)) - 32'h1;
    v = v & mask;
    if (sgn && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [13:0] mk_cw(input bit rfw, input bit we,
                                        input logic [1:0] src,
                                        input logic [4:0] rd,
                                        input logic [2:0] f3);
    return {1'($urandom), rfw, we, src, 1'($urandom), rd, f3};
  endfunction

  // fk: cycle (relative to start) from which flush is held; -1 none, -2 random
  task automatic do_op(input logic [13:0] cw, input logic [31:0] adr,
                       input logic [31:0] alu, input logic [31:0] b,
                       input logic [31:0] rdata, input int rdy,
                       input int rspd, input int fk);
    bit we, ld, is_mem, mis, exp_done;
    int sz, off, done_k, idle_k, exp_acc, d0, a0, s0;
    logic [31:0] wd;
    we     = cw[11];
    ld     = (cw[10:9] == 2'b01) && !we;
    is_mem = we || ld;
    sz     = (cw[1:0] == 2'b00) ? 1 : (cw[1:0] == 2'b01) ? 2 : 4;
    off    = int'(adr[1:0]);
    mis    = is_mem && ((adr % sz) != 0);
    if (!is_mem)   done_k = 0;
    else if (mis)  done_k = 1;
    else if (we)   done_k = 2 + rdy;
    else           done_k = 3 + rdy + rspd;
    if (fk == -2)
      fk = ($urandom % 4 == 0) ? $urandom_range(0, done_k + 1) : -1;
    if (!is_mem && fk > 0) fk = -1;
    if (fk == 0) begin
      exp_done = 0; idle_k = 1; exp_acc = 0;
    end else if (fk < 0 || fk > done_k) begin
      exp_done = 1; idle_k = done_k + 1; exp_acc = (is_mem && !mis) ? 1 : 0;
    end else if (mis) begin
      exp_done = 0; idle_k = 2; exp_acc = 0;
    end else if (fk < 1 + rdy) begin
      exp_done = 0; idle_k = fk + 1; exp_acc = 0;
    end else if (we) begin
      exp_done = 0; idle_k = fk + 1; exp_acc = 1;
    end else begin
      exp_done = 0; exp_acc = 1;
      idle_k = ((fk > 2 + rdy + rspd) ? fk : 2 + rdy + rspd) + 1;
    end
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = b[8*(i % sz) +: 8];
    exp_req_ok = is_mem && !mis;
    exp_addr   = adr & ~32'h3;
    exp_we     = we;
    exp_wstrb  = we ? 4'(((1 << sz) - 1) << off) : 4'h0;
    exp_wdata  = we ? wd : 32'h0;
    exp_rd     = cw[7:3];
    exp_mis    = mis;
    if (!is_mem) begin
      exp_wb = alu; exp_rfwb = cw[12];
    end else if (mis || we) begin
      exp_wb = 32'h0; exp_rfwb = 1'b0;
    end else begin
      exp_wb   = load_val(rdata, off, sz, !cw[2]);
      exp_rfwb = cw[12];
    end
    rdy_delay = rdy;
    rsp_delay = rspd;
    rsp_data  = rdata;
    last_wb   = 32'hdead_beef;
    last_addr = 32'hdead_beef;
    @(posedge clk);
    #1;
    control_word_ex = cw;
    calculated_adr  = adr;
    ALU_result      = alu;
    regfileb_ex     = b;
    valid_mem       = 1'b1;
    done_ex         = 1'b1;
    flush_mem       = 1'b0;
    d0 = done_n;
    a0 = acc_n;
    s0 = cyc;
    for (int k = 0; k < idle_k; k++) begin
      if (k == fk) flush_mem = 1'b1;
      @(negedge clk);
      #1;
      if (is_mem && fk != 0 && k == idle_k - 1) chk("busy_hold", 32'(busy), 32'h1);
      @(posedge clk);
      #1;
    end
    valid_mem = 1'b0;
    flush_mem = 1'b0;
    chk("busy_idle", 32'(busy), 32'h0);
    chk("done_count", 32'(done_n - d0), 32'(exp_done));
    if (exp_done) chk("latency", 32'(done_at - s0), 32'(done_k));
    chk("accept_count", 32'(acc_n - a0), 32'(exp_acc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit we;
    logic [1:0] src;
    int kind;
    logic [31:0] adr;
    rst = 1'b0;
    valid_mem = 1'b0;
    flush_mem = 1'b0;
    done_ex = 1'b0;
    control_word_ex = '0;
    calculated_adr = '0;
    ALU_result = '0;
    regfileb_ex = '0;
    exp_req_ok = 1'b0;
    #3;
    chk("rst_done", 32'(done_mem), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // SB at byte 3
    do_op(mk_cw(1, 1, 2'b00, 5'd7, 3'b000), 32'h0000_1003, 32'h0,
          32'hAABB_CCDD, 32'h0, 0, 0, -1);
    chk("sb_addr", last_addr, 32'h0000_1000);
    chk("sb_wstrb", 32'(last_wstrb), 32'h8);
    chk("sb_wdata", last_wdata, 32'hDDDD_DDDD);
    chk("sb_we", 32'(last_we), 32'h1);
    chk("sb_rfwb", 32'(last_rfwb), 32'h0);

    do_op(mk_cw(1, 0, 2'b01, 5'd5, 3'b001), 32'h0000_2002, 32'h0,
          32'h0, 32'h8001_1234, 0, 2, -1);
    chk("lh_wb", last_wb, 32'hFFFF_8001);
    chk("lh_rfwb", 32'(last_rfwb), 32'h1);
    chk("lh_rd", 32'(last_rd), 32'h5);
    do_op(mk_cw(1, 0, 2'b01, 5'd6, 3'b101), 32'h0000_2002, 32'h0,
          32'h0, 32'h8001_1234, 0, 2, -1);
    chk("lhu_wb", last_wb, 32'h0000_8001);
    do_op(mk_cw(1, 0, 2'b01, 5'd8, 3'b000), 32'h0000_2001, 32'h0,
          32'h0, 32'h8001_1234, 1, 0, -1);
    chk("lb_wb", last_wb, 32'h0000_0012);

    do_op(mk_cw(1, 0, 2'b01, 5'd9, 3'b010), 32'h0000_2001, 32'h0,
          32'h0, 32'h0, 0, 0, -1);
    chk("lw_mis", 32'(last_mis), 32'h1);
    chk("lw_mis_rfwb", 32'(last_rfwb), 32'h0);

    // Flush in WAIT, response three cycles later, then an ADD
    do_op(mk_cw(1, 0, 2'b01, 5'd10, 3'b010), 32'h0000_3000, 32'h0,
          32'h0, 32'h1111_2222, 0, 3, 2);
    do_op(mk_cw(1, 0, 2'b00, 5'd11, 3'b000), 32'h0, 32'h0000_0077,
          32'h0, 32'h0, 0, 0, -1);
    chk("add_wb", last_wb, 32'h0000_0077);

    // Ready withheld, flushed in the third REQ cycle
    do_op(mk_cw(0, 1, 2'b00, 5'd12, 3'b010), 32'h0000_4004, 32'h0,
          32'h1234_5678, 32'h0, 5, 0, 3);

    do_op(mk_cw(1, 0, 2'b10, 5'd13, 3'b000), 32'h0, 32'h0000_0055,
          32'h0, 32'h0, 0, 0, -1);
    chk("alu_wb", last_wb, 32'h0000_0055);
    chk("alu_rfwb", 32'(last_rfwb), 32'h1);

    // Flush while idle blocks the start
    do_op(mk_cw(1, 0, 2'b01, 5'd14, 3'b010), 32'h0000_5000, 32'h0,
          32'h0, 32'h0, 0, 0, 0);

    // Reset during WAIT; the late response must be ignored
    rdy_delay = 0;
    rsp_delay = 6;
    rsp_data  = 32'hCAFE_F00D;
    exp_req_ok = 1'b1;
    exp_addr  = 32'h0000_6000;
    exp_we    = 1'b0;
    exp_wstrb = 4'h0;
    exp_wdata = 32'h0;
    @(posedge clk);
    #1;
    control_word_ex = mk_cw(1, 0, 2'b01, 5'd15, 3'b010);
    calculated_adr  = 32'h0000_6000;
    valid_mem = 1'b1;
    done_ex   = 1'b1;
    d0 = done_n;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", 32'(busy), 32'h1);
    valid_mem = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done_mem), 32'h0);
    chk("mid_rst_wb", wb_data, 32'h0);
    chk("mid_rst_rfwb", 32'(rf_wb_mem), 32'h0);
    chk("mid_rst_mis", 32'(misaligned), 32'h0);
    chk("mid_rst_req", 32'(bus.mem_req_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("late_rsp_done", 32'(done_n - d0), 32'h0);
    chk("late_rsp_busy", 32'(busy), 32'h0);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 2);
      we   = (kind == 2);
      src  = (kind == 1) ? 2'b01 : 2'($urandom);
      if (kind == 0 && src == 2'b01) src = 2'b11;
      adr = $urandom;
      if ($urandom % 2 == 0) adr[1:0] = 2'b00;
      do_op(mk_cw(1'($urandom), we, src, 5'($urandom), 3'($urandom)),
            adr, $urandom, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), -2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
